// File: rtl/if_prefetch_pkg.sv
// Shared fetch-side definitions: address/instruction widths, NOP encoding,
// prefetch defaults and the instruction-queue entry layout.
package if_prefetch_pkg;

    localparam int unsigned SYS_ADDR_SPACE = 32;
    localparam int unsigned INST_WIDTH     = 32;

    // addi x0, x0, 0
    localparam logic [INST_WIDTH-1:0]     INST_NOP     = 32'h0000_0013;
    localparam logic [SYS_ADDR_SPACE-1:0] RESET_PC_DEF = 32'h0000_0000;
    localparam int unsigned               DEPTH_DEF    = 4;

    // One queued instruction together with the address it was fetched from
    typedef struct packed {
        logic [SYS_ADDR_SPACE-1:0] pc;
        logic [INST_WIDTH-1:0]     inst;
    } fetch_entry_t;

    // Clear the byte offset so every fetch address is word aligned
    function automatic logic [SYS_ADDR_SPACE-1:0] word_align(input logic [SYS_ADDR_SPACE-1:0] a);
        return a & ~SYS_ADDR_SPACE'(3);
    endfunction

endpackage

// File: rtl/if_prefetch_fifo.sv
// inst_fifo: parameterised synchronous FIFO with push, pop, flush and an
// occupancy count. Used both for the instruction queue and the address tags.
module inst_fifo #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 4,
    localparam int unsigned AW   = $clog2(DEPTH),
    localparam int unsigned CW   = $clog2(DEPTH + 1)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             flush_i,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] wdata_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic [CW-1:0]    count_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push, do_pop;

    // Next-state pointers and count; flush wins, a push into a full FIFO is
    // accepted only when a pop frees the slot in the same cycle
    always_comb begin
        do_pop   = !flush_i && pop_i && (count_q != '0);
        do_push  = !flush_i && push_i && ((count_q != CW'(DEPTH)) || do_pop);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
            count_d = count_q + CW'(do_push) - CW'(do_pop);
        end
    end

    // Pointer and count registers
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array, written only on an accepted push
    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata_i;
    end

    // Head entry is presented combinationally
    always_comb begin
        rdata_o = mem_q[rd_ptr_q];
        count_o = count_q;
    end

endmodule

// File: rtl/if_prefetch.sv
// Instruction prefetch unit: issues in-order fetches while queue credit is
// available, tags responses with their address, and flushes/refetches on a
// branch redirect while discarding responses still in flight.
module if_prefetch
    import if_prefetch_pkg::*;
#(
    parameter int unsigned                DEPTH    = DEPTH_DEF,
    parameter logic [SYS_ADDR_SPACE-1:0]  RESET_PC = RESET_PC_DEF
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      stall_i,
    input  logic [SYS_ADDR_SPACE-1:0] pc_i,
    input  logic                      pc_we,
    output logic                      imem_req_o,
    output logic [SYS_ADDR_SPACE-1:0] imem_addr_o,
    input  logic                      imem_ready_i,
    input  logic                      imem_rvalid_i,
    input  logic [INST_WIDTH-1:0]     imem_rdata_i,
    output logic [INST_WIDTH-1:0]     inst_o,
    output logic [SYS_ADDR_SPACE-1:0] pc_o,
    output logic                      valid_o,
    output logic                      anomaly_o
);

    localparam int unsigned CW      = $clog2(DEPTH + 1);
    localparam logic [CW:0] DEPTH_W = (CW + 1)'(DEPTH);

    logic [SYS_ADDR_SPACE-1:0] fpc_q, fpc_d;
    logic [CW-1:0]             outst_q, outst_d;
    logic [CW-1:0]             drop_q, drop_d;
    logic                      anomaly_q, anomaly_d;

    logic [CW-1:0]             q_count, tag_count;
    logic [SYS_ADDR_SPACE-1:0] tag_head;
    fetch_entry_t              q_head, q_wdata;
    logic [CW:0]               credit_used;
    logic                      req, accept, rsp_any, rsp_live, rsp_keep;
    logic                      tag_pop, q_pop;

    // Request credit and response classification. A response is live only
    // when nothing is pending discard and something is actually outstanding;
    // the outstanding==0 guard swallows stray responses after reset.
    always_comb begin
        credit_used = {1'b0, q_count} + {1'b0, outst_q};
        req         = !rst_i && !pc_we && (credit_used < DEPTH_W);
        accept      = req && imem_ready_i;
        rsp_any     = imem_rvalid_i && (outst_q != '0);
        rsp_live    = rsp_any && !pc_we && (drop_q == '0);
        tag_pop     = rsp_live && (tag_count != '0);
        rsp_keep    = tag_pop && (q_count != CW'(DEPTH));
        q_pop       = (q_count != '0) && !stall_i && !pc_we;
        q_wdata     = '{pc: tag_head, inst: imem_rdata_i};
    end

    // Fetch PC, outstanding/drop bookkeeping and sticky anomaly flag.
    // The drop count takes the post-update outstanding value, so a response
    // retired in the redirect cycle itself is not counted twice.
    always_comb begin
        fpc_d     = fpc_q;
        outst_d   = outst_q;
        drop_d    = drop_q;
        anomaly_d = anomaly_q;
        if (accept) fpc_d = fpc_q + SYS_ADDR_SPACE'(4);
        if (accept && !rsp_any)      outst_d = outst_q + CW'(1);
        else if (!accept && rsp_any) outst_d = outst_q - CW'(1);
        if (pc_we) begin
            fpc_d  = word_align(pc_i);
            drop_d = outst_d;
            if (pc_i[1:0] != 2'b00) anomaly_d = 1'b1;
        end else if (rsp_any && (drop_q != '0)) begin
            drop_d = drop_q - CW'(1);
        end
        if (rsp_live && !rsp_keep) anomaly_d = 1'b1;
    end

    // Control state registers
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            fpc_q     <= RESET_PC;
            outst_q   <= '0;
            drop_q    <= '0;
            anomaly_q <= 1'b0;
        end else begin
            fpc_q     <= fpc_d;
            outst_q   <= outst_d;
            drop_q    <= drop_d;
            anomaly_q <= anomaly_d;
        end
    end

    // In-order address tags for requests accepted by memory
    inst_fifo #(
        .WIDTH (SYS_ADDR_SPACE),
        .DEPTH (DEPTH)
    ) u_tag_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .flush_i (pc_we),
        .push_i  (accept),
        .pop_i   (tag_pop),
        .wdata_i (fpc_q),
        .rdata_o (tag_head),
        .count_o (tag_count)
    );

    // Fetched instruction queue
    inst_fifo #(
        .WIDTH ($bits(fetch_entry_t)),
        .DEPTH (DEPTH)
    ) u_inst_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .flush_i (pc_we),
        .push_i  (rsp_keep),
        .pop_i   (q_pop),
        .wdata_i (q_wdata),
        .rdata_o (q_head),
        .count_o (q_count)
    );

    // Output drive; an empty queue presents a NOP at address zero
    always_comb begin
        imem_req_o  = req;
        imem_addr_o = fpc_q;
        valid_o     = (q_count != '0);
        inst_o      = valid_o ? q_head.inst : INST_NOP;
        pc_o        = valid_o ? q_head.pc   : '0;
        anomaly_o   = anomaly_q;
    end

endmodule

// File: tb/tb_if_prefetch.sv
// Scoreboard bench for if_prefetch: a latency-modelled memory issues
// responses, expected {pc, inst} pairs are queued per surviving response and
// a monitor compares every instruction the DUT hands to the decode stage.
module tb_if_prefetch;
    import if_prefetch_pkg::*;

    localparam logic [31:0] TB_RESET_PC = 32'h0000_0000;
    localparam int unsigned RAND_POPS   = 10000;
    localparam int unsigned CYC_BUDGET  = 70000;

    logic        clk = 1'b0;
    logic        rst_i = 1'b1;
    logic        stall_i = 1'b0;
    logic [31:0] pc_i = '0;
    logic        pc_we = 1'b0;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_ready_i = 1'b0;
    logic        imem_rvalid_i = 1'b0;
    logic [31:0] imem_rdata_i = '0;
    logic [31:0] inst_o;
    logic [31:0] pc_o;
    logic        valid_o;
    logic        anomaly_o;

    always #5 clk = ~clk;

    if_prefetch #(
        .DEPTH    (4),
        .RESET_PC (TB_RESET_PC)
    ) dut (
        .clk_i         (clk),
        .rst_i         (rst_i),
        .stall_i       (stall_i),
        .pc_i          (pc_i),
        .pc_we         (pc_we),
        .imem_req_o    (imem_req_o),
        .imem_addr_o   (imem_addr_o),
        .imem_ready_i  (imem_ready_i),
        .imem_rvalid_i (imem_rvalid_i),
        .imem_rdata_i  (imem_rdata_i),
        .inst_o        (inst_o),
        .pc_o          (pc_o),
        .valid_o       (valid_o),
        .anomaly_o     (anomaly_o)
    );

    typedef struct { logic [31:0] pc; logic [31:0] inst; } exp_t;
    typedef struct { logic [31:0] addr; int unsigned ep; int unsigned due; } pend_t;

    exp_t        exp_q[$];
    pend_t       pend[$];
    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;
    int unsigned cyc = 0;
    int unsigned epoch = 0;
    int unsigned pops = 0;
    logic [31:0] model_fpc = TB_RESET_PC;
    logic        model_anom = 1'b0;

    logic        held_v = 1'b0;
    logic [31:0] held_pc, held_inst;
    exp_t        mon_e;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'hC3A5_5A3C;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_bad++;
            $display("FAIL %s: actual %h required %h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    task automatic chk_b(input string name, input logic act, input logic expv);
        n_cmp++;
        if (act !== expv) begin
            n_bad++;
            $display("FAIL %s: actual %b required %b (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    task automatic reset_dut();
        @(posedge clk);
        #1;
        rst_i = 1'b1;
        stall_i = 1'b0;
        pc_we = 1'b0;
        imem_ready_i = 1'b0;
        imem_rvalid_i = 1'b0;
        pend.delete();
        exp_q.delete();
        epoch++;
        model_fpc = TB_RESET_PC;
        model_anom = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_b("rst_req", imem_req_o, 1'b0);
        chk_b("rst_valid", valid_o, 1'b0);
        chk("rst_inst", inst_o, INST_NOP);
        chk("rst_pc", pc_o, 32'h0);
        chk_b("rst_anomaly", anomaly_o, 1'b0);
    endtask

    // One clock of stimulus: memory model delivers the oldest due response,
    // accepted requests are checked against the reference fetch PC.
    task automatic do_cycle(input bit st, input bit we, input logic [31:0] tgt,
                            input bit rdy, input int unsigned lat, input bit stray);
        pend_t d;
        bit    dv;
        @(posedge clk);
        #1;
        cyc++;
        rst_i = 1'b0;
        stall_i = st;
        pc_we = we;
        pc_i = tgt;
        imem_ready_i = rdy;
        dv = 1'b0;
        if (pend.size() != 0 && pend[0].due <= cyc) begin
            d = pend.pop_front();
            dv = 1'b1;
            imem_rvalid_i = 1'b1;
            imem_rdata_i = mem_word(d.addr);
        end else begin
            imem_rvalid_i = stray;
            imem_rdata_i = $urandom;
        end
        @(negedge clk);
        chk_b("anomaly", anomaly_o, model_anom);
        if (imem_req_o && imem_ready_i) begin
            chk("req_addr", imem_addr_o, model_fpc);
            pend.push_back('{addr: model_fpc, ep: epoch, due: cyc + lat});
            model_fpc = model_fpc + 32'd4;
        end
        if (we) begin
            chk_b("req_suppressed", imem_req_o, 1'b0);
            epoch++;
            model_fpc = tgt & ~32'h3;
            if (tgt[1:0] != 2'b00) model_anom = 1'b1;
            exp_q.delete();
        end else if (dv && d.ep == epoch) begin
            exp_q.push_back('{pc: d.addr, inst: mem_word(d.addr)});
        end
    endtask

    // Monitor: every consumed head entry must match the scoreboard
    always @(negedge clk) begin
        if (rst_i) begin
            held_v = 1'b0;
        end else begin
            if (held_v) begin
                chk("stall_hold_pc", pc_o, held_pc);
                chk("stall_hold_inst", inst_o, held_inst);
                held_v = 1'b0;
            end
            if (valid_o) begin
                if (!pc_we && stall_i) begin
                    held_v = 1'b1;
                    held_pc = pc_o;
                    held_inst = inst_o;
                end else if (!pc_we) begin
                    pops++;
                    if (exp_q.size() == 0) begin
                        n_cmp++;
                        n_bad++;
                        $display("FAIL unexpected_pop: actual pc %h inst %h required no valid entry (cycle %0d)",
                                 pc_o, inst_o, cyc);
                    end else begin
                        mon_e = exp_q.pop_front();
                        chk("pop_pc", pc_o, mon_e.pc);
                        chk("pop_inst", inst_o, mon_e.inst);
                    end
                end
            end else begin
                chk("idle_inst", inst_o, INST_NOP);
                chk("idle_pc", pc_o, 32'h0);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: actual timeout required $finish (cycle %0d)", cyc);
        $fatal(1);
    end

    initial begin
        bit          st, we, rdy, seen, mid_reset;
        logic [31:0] tgt;
        int unsigned lat;

        reset_dut();

        // Cold start with 1-cycle memory
        for (int k = 1; k <= 10; k++) begin
            do_cycle(1'b0, 1'b0, 32'h0, 1'b1, 1, 1'b0);
            if (k == 1) chk_b("first_req", imem_req_o, 1'b1);
            if (k < 3) begin
                chk_b("early_valid", valid_o, 1'b0);
            end else begin
                chk_b("stream_valid", valid_o, 1'b1);
                chk("stream_pc", pc_o, 32'(4 * (k - 3)));
            end
        end

        // Long stall fills the queue and stops requests
        for (int k = 1; k <= 10; k++) begin
            do_cycle(1'b1, 1'b0, 32'h0, 1'b1, 1, 1'b0);
            if (k >= 6) chk_b("full_no_req", imem_req_o, 1'b0);
        end
        repeat (20) do_cycle(1'b0, 1'b0, 32'h0, 1'b1, 1, 1'b0);

        // Redirect coincident with a response and a stall
        do_cycle(1'b1, 1'b1, 32'h100, 1'b1, 1, 1'b0);
        do_cycle(1'b0, 1'b0, 32'h0, 1'b1, 1, 1'b0);
        chk_b("flush_empty", valid_o, 1'b0);
        chk_b("redir_req", imem_req_o, 1'b1);
        chk("redir_addr", imem_addr_o, 32'h100);
        do_cycle(1'b0, 1'b0, 32'h0, 1'b1, 1, 1'b0);
        chk_b("redir_wait", valid_o, 1'b0);
        do_cycle(1'b0, 1'b0, 32'h0, 1'b1, 1, 1'b0);
        chk_b("redir_valid", valid_o, 1'b1);
        chk("redir_pc", pc_o, 32'h100);
        repeat (10) do_cycle(1'b0, 1'b0, 32'h0, 1'b1, 1, 1'b0);

        // Redirect with several responses in flight (3-cycle memory)
        repeat (12) do_cycle(1'b0, 1'b0, 32'h0, 1'b1, 3, 1'b0);
        do_cycle(1'b0, 1'b1, 32'h100, 1'b1, 3, 1'b0);
        seen = 1'b0;
        for (int k = 0; k < 20; k++) begin
            do_cycle(1'b0, 1'b0, 32'h0, 1'b1, 3, 1'b0);
            if (valid_o && !seen) begin
                chk("redir2_pc", pc_o, 32'h100);
                seen = 1'b1;
            end
        end
        chk_b("redir2_seen", seen, 1'b1);

        // Misaligned redirect
        repeat (5) do_cycle(1'b0, 1'b0, 32'h0, 1'b1, 1, 1'b0);
        do_cycle(1'b0, 1'b1, 32'h102, 1'b1, 1, 1'b0);
        do_cycle(1'b0, 1'b0, 32'h0, 1'b1, 1, 1'b0);
        chk_b("mis_anomaly", anomaly_o, 1'b1);
        chk("mis_addr", imem_addr_o, 32'h100);
        repeat (8) do_cycle(1'b0, 1'b0, 32'h0, 1'b1, 1, 1'b0);

        // Fetch PC wrap at the top of the address space
        do_cycle(1'b0, 1'b1, 32'hFFFF_FFF8, 1'b1, 1, 1'b0);
        repeat (12) do_cycle(1'b0, 1'b0, 32'h0, 1'b1, 1, 1'b0);

        // Stray responses after reset, before any accepted request
        reset_dut();
        for (int k = 0; k < 3; k++) begin
            do_cycle(1'b0, 1'b0, 32'h0, 1'b0, 1, (k < 2));
            chk_b("stray_ignored", valid_o, 1'b0);
        end

        // Randomised traffic with one mid-run reset
        mid_reset = 1'b0;
        while (pops < RAND_POPS && cyc < CYC_BUDGET) begin
            st  = ($urandom_range(0, 3) == 0);
            we  = ($urandom_range(0, 149) == 0);
            rdy = ($urandom_range(0, 9) < 7);
            lat = $urandom_range(1, 5);
            case ($urandom_range(0, 3))
                0:       tgt = 32'hFFFF_FFF0;
                1:       tgt = $urandom;
                default: tgt = $urandom_range(0, 32'h0000_FFFF) & ~32'h3;
            endcase
            do_cycle(st, we, tgt, rdy, lat, 1'b0);
            if (!mid_reset && pops >= RAND_POPS / 2) begin
                reset_dut();
                mid_reset = 1'b1;
            end
        end
        chk_b("random_progress", (pops >= RAND_POPS), 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/if_prefetch.md
IF_PREFETCH -- requirements
Module: if_prefetch

Interface
REQ-001 Parameter DEPTH, default 4, queue entries (power of two, 2..16).
REQ-002 Parameter RESET_PC, default 32'h0000_0000, first fetch address after reset.
REQ-003 clk_i  input  1  single clock; all state on rising edge.
REQ-004 rst_i  input  1  reset, asynchronous, active-high.
REQ-005 stall_i  input  1  hazard-unit hold; head entry not consumed.
REQ-006 pc_i  input  32  branch-unit redirect target.
REQ-007 pc_we  input  1  redirect strobe; flush and refetch from pc_i.
REQ-008 imem_req_o  output  1  fetch request valid.
REQ-009 imem_addr_o  output  32  fetch address, word aligned.
REQ-010 imem_ready_i  input  1  memory accepts request this cycle.
REQ-011 imem_rvalid_i  input  1  in-order response valid.
REQ-012 imem_rdata_i  input  32  response instruction word.
REQ-013 inst_o  output  32  instruction to IF_ID.
REQ-014 pc_o  output  32  address of inst_o.
REQ-015 valid_o  output  1  inst_o/pc_o hold a real fetched instruction.
REQ-016 anomaly_o  output  1  sticky error flag.

Function
REQ-017 Fetch PC register fpc issues imem_req_o=1 with imem_addr_o=fpc whenever (queue count + outstanding) < DEPTH and no drop is pending for this cycle; fpc += 4 on each accepted request (req & ready).
REQ-018 Outstanding counter increments on accepted request, decrements on imem_rvalid_i, and does not change when both occur in the same cycle.
REQ-019 Each non-dropped response is pushed as {pc, instr}; pc comes from a small in-order address tag FIFO of depth DEPTH.
REQ-020 Head entry drives inst_o/pc_o combinationally with valid_o=1; when the queue is empty, inst_o=32'h0000_0013 (NOP), pc_o=0, valid_o=0.
REQ-021 Pop occurs when valid_o & !stall_i; the next entry appears the following cycle.
REQ-022 On pc_we: flush queue and tag FIFO; load fpc<=pc_i; set drop count = outstanding (plus 1 if a request is accepted that same cycle); suppress imem_req_o that cycle.
REQ-023 While drop count > 0, each imem_rvalid_i decrements the count and is discarded; a response in the pc_we cycle itself is also discarded.
REQ-024 pc_we overrides stall_i and pop in the same cycle.
REQ-025 Redirect latency: pc_we at cycle N gives imem_req_o with addr=pc_i at N+1; with 1-cycle memory, valid_o=1 at N+3.
REQ-026 Full (count==DEPTH): no request is issued; simultaneous push and pop keeps count unchanged.
REQ-027 Response when the queue is full is impossible by REQ-017; if it occurs anyway, drop it and set anomaly_o.
REQ-028 pc_we with pc_i[1:0]!=0 sets anomaly_o; fpc loads {pc_i[31:2],2'b00}.
REQ-029 fpc wraps 32'hFFFF_FFFC -> 0 without error.

Reset
REQ-030 On rst_i: fpc=RESET_PC, queue/tag FIFO empty, outstanding=0, drop=0, anomaly_o=0, imem_req_o=0, valid_o=0, inst_o=NOP, pc_o=0.
REQ-031 Reset mid-transaction discards all in-flight responses; responses arriving after reset deassertion but before any new request shall be ignored, using drop=0 with outstanding=0 as the discard guard.
REQ-032 The first request is issued in the first cycle after rst_i deasserts.

Structure
REQ-033 NOP encoding, RESET_PC default and DEPTH default shall reside in the shared general-define header alongside SYS_ADDR_SPACE/INST_WIDTH.
REQ-034 The queue shall be a separate sub-module inst_fifo (parameterised width/depth sync FIFO with push, pop, flush, count).

Verification
REQ-035 Reset, 1-cycle memory, no stall -> requests 0x0,0x4,0x8...; valid_o=1 with pc_o=0x0 at cycle 3, then one instruction per cycle.
REQ-036 stall_i held 10 cycles -> inst_o/pc_o constant; count reaches 4; imem_req_o=0 while full; order preserved after release.
REQ-037 pc_we=1, pc_i=0x100 with 2 outstanding -> both old responses dropped; next valid_o shows pc_o=0x100.
REQ-038 pc_we coincident with rvalid and stall_i -> queue empty next cycle, valid_o=0, stall ignored.
REQ-039 pc_i=0x102 redirect -> anomaly_o=1 sticky, fetch resumes at 0x100.
REQ-040 Random ready/rvalid latency 1-5 cycles, 10k instructions vs reference PC model -> no loss, duplication or reorder.
